// File: rtl/piezo_pulse_gen_if.sv
// Request, divider and drive signals of piezo_pulse_gen bundled as one interface.
// drive_n exists only when PIEZO_DEADTIME_EN is defined.
interface piezo_pulse_gen_if;
  logic        start;
  logic        abort;
  logic [15:0] freq;
  logic [15:0] pulse_cnt;
  logic        div_go;
  logic [15:0] div_divisor;
  logic [15:0] div_dividend;
  logic [15:0] div_quotient;
  logic        div_done;
  logic        drive;
`ifdef PIEZO_DEADTIME_EN
  logic        drive_n;
`endif
  logic        busy;
  logic        pulse_done;
  logic        err;

  // Requester and divider side
  modport master (
    output start, abort, freq, pulse_cnt, div_quotient, div_done,
    input  div_go, div_divisor, div_dividend, drive, busy, pulse_done, err
`ifdef PIEZO_DEADTIME_EN
    , input drive_n
`endif
  );

  // Pulse generator side
  modport slave (
    input  start, abort, freq, pulse_cnt, div_quotient, div_done,
    output div_go, div_divisor, div_dividend, drive, busy, pulse_done, err
`ifdef PIEZO_DEADTIME_EN
    , output drive_n
`endif
  );
endinterface

// File: rtl/piezo_pulse_gen.sv
// Launches the divider for period = PERIOD_NUM / freq, then emits pulse_cnt square pulses.
// Optional PIEZO_DEADTIME_EN adds complementary drive_n with DEADTIME low gaps after each edge.
module piezo_pulse_gen #(
  parameter logic [15:0] PERIOD_NUM = 16'd60000,
  parameter int unsigned MIN_PERIOD = 4,
  parameter int unsigned DEADTIME   = 2
) (
  input  logic             clk,
  input  logic             rst,
  piezo_pulse_gen_if.slave pif
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LAUNCH = 3'd1;
  localparam logic [2:0] GUARD  = 3'd2;
  localparam logic [2:0] WAIT   = 3'd3;
  localparam logic [2:0] CHECK  = 3'd4;
  localparam logic [2:0] RUN    = 3'd5;

  localparam int unsigned DEAD_W = $clog2(DEADTIME + 2);
`ifdef PIEZO_DEADTIME_EN
  localparam int unsigned       MIN_DT    = 2 * DEADTIME + 2;
  localparam logic [15:0]       MIN_EFF   = 16'((MIN_PERIOD > MIN_DT) ? MIN_PERIOD : MIN_DT);
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEADTIME);
`else
  localparam logic [15:0]       MIN_EFF   = 16'(MIN_PERIOD);
  localparam logic [DEAD_W-1:0] DEAD_LOAD = '0;
`endif

  logic [2:0]        state, state_nx;
  logic [15:0]       freq_q, freq_nx;
  logic [15:0]       remain, remain_nx;
  logic [15:0]       period, period_nx;
  logic [15:0]       phase, phase_nx;
  logic [15:0]       half;
  logic [DEAD_W-1:0] dead, dead_nx;
  logic              level, level_nx;
  logic              go_nx, done_nx, err_nx, drive_nx;
  logic [15:0]       dividend_q;
  logic              go_q, busy_q, drive_q, done_q, err_q;
`ifdef PIEZO_DEADTIME_EN
  logic              drive_n_q, drive_n_nx;
`endif

  assign half = {1'b0, period[15:1]};

  // level is the phase polarity; the dead counter blanks the start of each phase
  // and simply stays at zero when no dead time is configured.
  always_comb begin
    state_nx  = state;
    freq_nx   = freq_q;
    remain_nx = remain;
    period_nx = period;
    phase_nx  = phase;
    level_nx  = level;
    dead_nx   = (dead != '0) ? dead - DEAD_W'(1) : '0;
    go_nx     = 1'b0;
    done_nx   = 1'b0;
    err_nx    = 1'b0;
    if (pif.abort) begin
      state_nx = IDLE;
      level_nx = 1'b0;
      dead_nx  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (pif.start) begin
            freq_nx   = pif.freq;
            remain_nx = pif.pulse_cnt;
            if (pif.freq == '0) begin
              err_nx = 1'b1;
            end else begin
              state_nx = LAUNCH;
              go_nx    = 1'b1;
            end
          end
        end
        LAUNCH: state_nx = GUARD;
        GUARD:  state_nx = WAIT;
        WAIT: begin
          if (pif.div_done) begin
            period_nx = pif.div_quotient;
            state_nx  = CHECK;
          end
        end
        CHECK: begin
          if (period < MIN_EFF) begin
            err_nx   = 1'b1;
            state_nx = IDLE;
          end else if (remain == '0) begin
            done_nx  = 1'b1;
            state_nx = IDLE;
          end else begin
            state_nx = RUN;
            level_nx = 1'b1;
            phase_nx = half - 16'd1;
            dead_nx  = DEAD_LOAD;
          end
        end
        RUN: begin
          if (phase != '0) begin
            phase_nx = phase - 16'd1;
          end else if (level) begin
            level_nx = 1'b0;
            phase_nx = period - half - 16'd1;
            dead_nx  = DEAD_LOAD;
            if (remain != '0) remain_nx = remain - 16'd1;
          end else if (remain == '0) begin
            done_nx  = 1'b1;
            state_nx = IDLE;
          end else begin
            level_nx = 1'b1;
            phase_nx = half - 16'd1;
            dead_nx  = DEAD_LOAD;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
    drive_nx = (state_nx == RUN) && level_nx && (dead_nx == '0);
`ifdef PIEZO_DEADTIME_EN
    drive_n_nx = (state_nx == RUN) && !level_nx && (dead_nx == '0);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      freq_q     <= '0;
      remain     <= '0;
      period     <= '0;
      phase      <= '0;
      level      <= 1'b0;
      dead       <= '0;
      dividend_q <= '0;
      go_q       <= 1'b0;
      busy_q     <= 1'b0;
      drive_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef PIEZO_DEADTIME_EN
      drive_n_q  <= 1'b0;
`endif
    end else begin
      state      <= state_nx;
      freq_q     <= freq_nx;
      remain     <= remain_nx;
      period     <= period_nx;
      phase      <= phase_nx;
      level      <= level_nx;
      dead       <= dead_nx;
      dividend_q <= PERIOD_NUM;
      go_q       <= go_nx;
      busy_q     <= (state_nx != IDLE);
      drive_q    <= drive_nx;
      done_q     <= done_nx;
      err_q      <= err_nx;
`ifdef PIEZO_DEADTIME_EN
      drive_n_q  <= drive_n_nx;
`endif
    end
  end

  assign pif.div_go       = go_q;
  assign pif.div_divisor  = freq_q;
  assign pif.div_dividend = dividend_q;
  assign pif.drive        = drive_q;
  assign pif.busy         = busy_q;
  assign pif.pulse_done   = done_q;
  assign pif.err          = err_q;
`ifdef PIEZO_DEADTIME_EN
  assign pif.drive_n      = drive_n_q;
`endif

endmodule

// File: tb/tb_piezo_pulse_gen.sv
// Bench for piezo_pulse_gen: directed and random bursts against a cycle-indexed reference model,
// with a latency-randomized divider that presents a stale result on the cycle after div_go.
module tb_piezo_pulse_gen;

  localparam int PNUM = 60000;
`ifdef PIEZO_DEADTIME_EN
  localparam int MINP = 6;
  localparam int DT   = 2;
`else
  localparam int MINP = 4;
  localparam int DT   = 0;
`endif

  logic clk;
  logic rst;
  piezo_pulse_gen_if pif();

  piezo_pulse_gen #(.PERIOD_NUM(16'd60000), .MIN_PERIOD(4), .DEADTIME(2)) dut (
    .clk(clk),
    .rst(rst),
    .pif(pif)
  );

  int checks   = 0;
  int failures = 0;
  int burst    = 0;
  int e_freq, e_cnt, e_lat, e_abort;
  int div_lat  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {div_go, busy, drive, drive_n, pulse_done, err}
  function automatic logic [5:0] observed();
`ifdef PIEZO_DEADTIME_EN
    return {pif.div_go, pif.busy, pif.drive, pif.drive_n, pif.pulse_done, pif.err};
`else
    return {pif.div_go, pif.busy, pif.drive, 1'b0, pif.pulse_done, pif.err};
`endif
  endfunction

  // Expected outputs t cycles after the edge that accepted start.
  function automatic logic [5:0] model(input int t);
    int p, h, t0, k, ph;
    logic go, bz, dr, dn, pd, er, hi, act;
    go = 0; bz = 0; dr = 0; dn = 0; pd = 0; er = 0;
    if (e_abort >= 0 && t > e_abort) return '0;
    p  = (e_freq == 0) ? 0 : PNUM / e_freq;
    t0 = 5 + e_lat;
    if (e_freq == 0) begin
      er = (t == 1);
    end else if (t < t0) begin
      bz = 1;
      go = (t == 1);
    end else if (p < MINP) begin
      er = (t == t0);
    end else if (e_cnt == 0) begin
      pd = (t == t0);
    end else begin
      k = t - t0;
      if (k < e_cnt * p) begin
        bz  = 1;
        h   = p / 2;
        ph  = k % p;
        hi  = (ph < h);
        act = hi ? (ph >= DT) : (ph - h >= DT);
        dr  = hi && act;
        dn  = (DT != 0) && !hi && act;
      end else begin
        pd = (k == e_cnt * p);
      end
    end
    return {go, bz, dr, dn, pd, er};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Divider stand-in: stale result on the cycle after div_go, correct result div_lat cycles later.
  initial begin
    int age;
    bit pend;
    logic [15:0] q;
    age = 0; pend = 0; q = '0;
    pif.div_done = 1'b0;
    pif.div_quotient = '0;
    forever begin
      @(negedge clk);
      if (pif.div_go === 1'b1) begin
        q = (pif.div_divisor == 0) ? 16'hFFFF : pif.div_dividend / pif.div_divisor;
        pif.div_done = 1'b1;
        pif.div_quotient = q ^ 16'h5A5A;
        age = 0;
        pend = 1;
      end else if (pend) begin
        age++;
        if (age >= 2 + div_lat) begin
          pif.div_done = 1'b1;
          pif.div_quotient = q;
          pend = 0;
        end else if (age >= 2) begin
          pif.div_done = 1'b0;
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ab: abort cycle (-1 none), rs: cycle to pulse a competing start (-1 none), stop: early end (-1 none)
  task automatic run_burst(input int fr, input int cnt, input int lat,
                           input int ab, input int rs, input int stop);
    int p, horizon;
    e_freq = fr; e_cnt = cnt; e_lat = lat; e_abort = ab; div_lat = lat;
    burst++;
    p = (fr == 0) ? 0 : PNUM / fr;
    if (fr == 0) horizon = 4;
    else if (p < MINP || cnt == 0) horizon = 5 + lat + 2;
    else horizon = 5 + lat + cnt * p + 2;
    if (ab >= 0 && ab + 3 < horizon) horizon = ab + 3;
    if (stop >= 0) horizon = stop;
    @(negedge clk);
    pif.start = 1'b1;
    pif.freq = 16'(fr);
    pif.pulse_cnt = 16'(cnt);
    pif.abort = (ab == 0);
    for (int t = 1; t <= horizon; t++) begin
      @(negedge clk);
      chk($sformatf("burst%0d_t%0d", burst, t), 32'(observed()), 32'(model(t)));
      if (t == 2 && fr != 0 && ab != 0) begin
        chk($sformatf("burst%0d_divisor", burst), 32'(pif.div_divisor), 32'(fr));
        chk($sformatf("burst%0d_dividend", burst), 32'(pif.div_dividend), 32'(PNUM));
      end
      pif.start = (t == rs);
      pif.abort = (t == ab);
      if (t == rs) begin
        pif.freq = 16'd500;
        pif.pulse_cnt = 16'd7;
      end
    end
    if (fr != 0 && ab != 0)
      chk($sformatf("burst%0d_divisor_hold", burst), 32'(pif.div_divisor), 32'(fr));
    pif.start = 1'b0;
    pif.abort = 1'b0;
  endtask

  initial begin
    int l;
    rst = 1'b1;
    pif.start = 1'b0;
    pif.abort = 1'b0;
    pif.freq = '0;
    pif.pulse_cnt = '0;
    #3;
    chk("reset_outputs", 32'(observed()), 32'(0));
    chk("reset_div_bus", {pif.div_divisor, pif.div_dividend}, 32'(0));
    @(negedge clk);
    rst = 1'b0;

    l = $urandom_range(0, 5); run_burst(1000, 3, l, -1, -1, -1);
    l = $urandom_range(0, 5); run_burst(0, 3, l, -1, -1, -1);
    l = $urandom_range(0, 5); run_burst(20000, 3, l, -1, -1, -1);
    l = $urandom_range(0, 5); run_burst(1000, 0, l, -1, -1, -1);
    l = $urandom_range(0, 5); run_burst(1000, 5, l, 5 + l + 70, -1, -1);
    l = $urandom_range(0, 5); run_burst(1000, 2, l, -1, -1, -1);
    l = $urandom_range(0, 5); run_burst(1000, 3, l, -1, 5 + l + 40, -1);
    run_burst(1000, 2, 0, 0, -1, -1);

    // Async reset while drive is high: outputs drop without waiting for a clock.
    run_burst(1000, 3, 2, -1, -1, 5 + 2 + 4);
    #1 rst = 1'b1;
    #1;
    chk("async_reset_drop", 32'(observed()), 32'(0));
    @(negedge clk);
    chk("async_reset_hold", 32'(observed()), 32'(0));
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_reset_quiet", 32'(observed()), 32'(0));
    end

    for (int i = 0; i < 8; i++) begin
      int fr, cnt, lat;
      case ($urandom_range(0, 4))
        0:       fr = 0;
        1:       fr = $urandom_range(15001, 30000);
        default: fr = $urandom_range(1000, 12000);
      endcase
      cnt = $urandom_range(0, 4);
      lat = $urandom_range(0, 5);
      run_burst(fr, cnt, lat, -1, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
